// File: rtl/fifo_system.sv
//------------------------------------------------------------------------------
// fifo_system: word FIFO feeding a byte unpacker and an 8-tap sample delay line
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo_system #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] w,
  output logic [7:0]  A0,
  output logic [7:0]  A1,
  output logic [7:0]  A2,
  output logic [7:0]  A3,
  output logic [7:0]  A4,
  output logic [7:0]  A5,
  output logic [7:0]  A6,
  output logic [7:0]  A7,
  output logic        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   hold;
  state_t        state;
  logic [7:0]    taps [8];

  logic do_write;
  logic do_pop;
  logic empty;

  // Both full and empty decisions use the pre-edge count: no fall-through,
  // and a same-cycle pop never makes room for a write.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_write = enable && !full;
  assign do_pop   = ((state == IDLE) || (state == HIGH)) && !empty;

  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem[wr_ptr] <= w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_write, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
      for (int i = 0; i < 8; i++) begin
        taps[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        hold <= mem[rd_ptr];
      end
      if ((state == LOW) || (state == HIGH)) begin
        for (int i = 7; i > 0; i--) begin
          taps[i] <= taps[i-1];
        end
        taps[0] <= (state == LOW) ? hold[7:0] : hold[15:8];
      end
      case (state)
        IDLE:    state <= do_pop ? LOW : IDLE;
        LOW:     state <= HIGH;
        HIGH:    state <= do_pop ? LOW : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign A0 = taps[0];
  assign A1 = taps[1];
  assign A2 = taps[2];
  assign A3 = taps[3];
  assign A4 = taps[4];
  assign A5 = taps[5];
  assign A6 = taps[6];
  assign A7 = taps[7];

endmodule

`default_nettype wire

// File: tb/tb_fifo_system.sv
//------------------------------------------------------------------------------
// tb_fifo_system: directed stimulus with a word/byte scoreboard for fifo_system
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_system;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] w;
  logic [7:0]  A0, A1, A2, A3, A4, A5, A6, A7;
  logic        full;

  fifo_system #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .w      (w),
    .A0     (A0),
    .A1     (A1),
    .A2     (A2),
    .A3     (A3),
    .A4     (A4),
    .A5     (A5),
    .A6     (A6),
    .A7     (A7),
    .full   (full)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference: words accepted but not yet popped, bytes popped but not yet
  // shifted in, unpacker phase (0 idle, 1 low, 2 high) and expected taps.
  logic [15:0] wq [$];
  logic [7:0]  sb [$];
  int          phase;
  logic [7:0]  mt [8];

  task automatic check(input string tag);
    logic [63:0] got;
    logic [63:0] exp;
    logic        exp_full;
    got      = {A7, A6, A5, A4, A3, A2, A1, A0};
    exp      = {mt[7], mt[6], mt[5], mt[4], mt[3], mt[2], mt[1], mt[0]};
    exp_full = (wq.size() == DEPTH);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s taps observed=%h expected=%h", tag, got, exp);
    end
    vectors++;
    assert (full === exp_full) else begin
      miscompares++;
      $error("FAIL %s full observed=%b expected=%b", tag, full, exp_full);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [15:0] d, input string tag);
    logic       was_full;
    logic       was_empty;
    logic       pop;
    logic [15:0] word;
    reset  = r;
    enable = e;
    w      = d;
    @(posedge clk);
    if (r) begin
      wq.delete();
      sb.delete();
      phase = 0;
      for (int i = 0; i < 8; i++) mt[i] = 8'h00;
    end else begin
      was_full  = (wq.size() == DEPTH);
      was_empty = (wq.size() == 0);
      if (phase != 0) begin
        for (int i = 7; i > 0; i--) mt[i] = mt[i-1];
        if (sb.size() > 0) mt[0] = sb.pop_front();
        else               mt[0] = 8'hxx;
      end
      pop = ((phase == 0) || (phase == 2)) && !was_empty;
      if (pop) begin
        word = wq.pop_front();
        sb.push_back(word[7:0]);
        sb.push_back(word[15:8]);
      end
      if (e && !was_full) wq.push_back(d);
      case (phase)
        0:       phase = pop ? 1 : 0;
        1:       phase = 2;
        default: phase = pop ? 1 : 0;
      endcase
    end
    #1;
    check(tag);
  endtask

  initial begin
    int n;
    phase = 0;
    for (int i = 0; i < 8; i++) mt[i] = 8'h00;

    // Reset with a write request pending: nothing may be written.
    step(1'b1, 1'b1, 16'hFFFF, "reset0");
    step(1'b1, 1'b1, 16'hFFFF, "reset1");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, "post_reset");

    step(1'b0, 1'b1, 16'hBEEF, "single_wr");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, "single");

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, {8'(2*i+2), 8'(2*i+1)}, "stream_wr");
      step(1'b0, 1'b0, 16'h0000, "stream");
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0000, "stream_drain");
    vectors++;
    assert ({A7, A6, A5, A4, A3, A2, A1, A0} === 64'h0102030405060708) else begin
      miscompares++;
      $error("FAIL stream_final observed=%h expected=%h",
             {A7, A6, A5, A4, A3, A2, A1, A0}, 64'h0102030405060708);
    end

    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h1000 + 16'(i * 16'h0101), "overflow");
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 16'h0000, "overflow_drain");

    // Fill, then hit the cycle where a full FIFO pops from HIGH.
    n = 0;
    while (!((wq.size() == DEPTH) && (phase == 2)) && (n < 40)) begin
      step(1'b0, 1'b1, 16'h2000 + 16'(n), "fill");
      n++;
    end
    vectors++;
    assert (n < 40) else begin
      miscompares++;
      $error("FAIL fill_timeout observed=%0d expected=<40", n);
    end
    step(1'b0, 1'b1, 16'hAAAA, "simul_drop");
    vectors++;
    assert (wq.size() == DEPTH - 1 && full === 1'b0) else begin
      miscompares++;
      $error("FAIL simul_count observed=full%b expected=full0", full);
    end
    step(1'b0, 1'b1, 16'h5A5A, "simul_accept");
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 16'h0000, "simul_drain");

    // Build a backlog of five words with the unpacker in LOW, then reset.
    n = 0;
    while (!((wq.size() >= 5) && (phase == 1)) && (n < 40)) begin
      step(1'b0, 1'b1, 16'h3000 + 16'(n), "backlog");
      n++;
    end
    vectors++;
    assert (n < 40) else begin
      miscompares++;
      $error("FAIL backlog_timeout observed=%0d expected=<40", n);
    end
    step(1'b1, 1'b0, 16'h0000, "mid_reset");
    step(1'b0, 1'b1, 16'hC3D4, "after_reset_wr");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, "after_reset");
    vectors++;
    assert ({A2, A1, A0} === 24'h00D4C3) else begin
      miscompares++;
      $error("FAIL after_reset_final observed=%h expected=%h", {A2, A1, A0}, 24'h00D4C3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
